// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the BRAM responder.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_MEM,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port 32-bit block RAM with per-byte write enables and a registered read.
// The read register only updates when re is set, so it holds its word across writes.
module bram_sp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_WIDTH   = 10,
  parameter     INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic [IDX_WIDTH-1:0] addr,
  input  logic [3:0]           we,
  input  logic [31:0]          wdata,
  input  logic                 re,
  output logic [31:0]          rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read sharing the single address port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi4lite_bram_slave.sv
// AXI4-Lite responder in front of a single-port byte-enabled BRAM.
// Independent write and read FSMs share the RAM port; a write in W_MEM wins the
// port and a coincident read simply waits one cycle, so it sees the new data.
module axi4lite_bram_slave
  import axi_lite_pkg::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter                        INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                    IDX_WIDTH   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  logic                  aw_taken, aw_taken_n, w_taken, w_taken_n;
  logic                  awready_n, wready_n, bvalid_n;
  logic [1:0]            bresp_n;
  logic                  arready_n, rvalid_n;
  logic [1:0]            rresp_n;
  logic                  aw_hs, w_hs, ar_hs;

  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;

  logic [ADDR_WIDTH-1:0] wr_word, rd_word;
  logic                  wr_err, rd_err;
  logic                  w_mem;
  logic [IDX_WIDTH-1:0]  ram_addr;
  logic [3:0]            ram_we;
  logic                  ram_re;
  logic [31:0]           ram_rdata;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Address decode on the latched addresses; the low two bits drop out in the shift.
  assign wr_word = (aw_addr - BASE_ADDR) >> 2;
  assign rd_word = (ar_addr - BASE_ADDR) >> 2;
  assign wr_err  = (aw_addr < BASE_ADDR) || (wr_word >= DEPTH_LIMIT);
  assign rd_err  = (ar_addr < BASE_ADDR) || (rd_word >= DEPTH_LIMIT);

  // RAM port sharing: the write cycle owns the port, and is suppressed outright
  // when reset lands on it so no partial word is ever committed.
  assign w_mem    = (wr_state == W_MEM);
  assign ram_addr = w_mem ? wr_word[IDX_WIDTH-1:0] : rd_word[IDX_WIDTH-1:0];
  assign ram_we   = (w_mem && !wr_err && !rst) ? w_strb : 4'b0000;
  assign ram_re   = (rd_state == R_MEM) && !w_mem && !rd_err;

  // Read data is the RAM output register, forced to zero unless an OKAY beat is valid.
  assign s_axi_rdata = (s_axi_rvalid && (s_axi_rresp == RESP_OKAY)) ? ram_rdata : 32'h0;

  bram_sp #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_WIDTH   (IDX_WIDTH),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (w_data),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Capture AW, W and AR payloads on their handshakes.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr <= s_axi_awaddr;
    if (w_hs) begin
      w_data <= s_axi_wdata;
      w_strb <= s_axi_wstrb;
    end
    if (ar_hs) ar_addr <= s_axi_araddr;
  end

  // Write FSM next state and next values of its registered outputs.
  always_comb begin
    wr_state_n = wr_state;
    aw_taken_n = aw_taken;
    w_taken_n  = w_taken;
    awready_n  = s_axi_awready;
    wready_n   = s_axi_wready;
    bvalid_n   = s_axi_bvalid;
    bresp_n    = s_axi_bresp;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs) aw_taken_n = 1'b1;
        if (w_hs)  w_taken_n  = 1'b1;
        awready_n = !(aw_taken || aw_hs);
        wready_n  = !(w_taken || w_hs);
        if ((aw_taken || aw_hs) && (w_taken || w_hs)) begin
          wr_state_n = W_MEM;
          aw_taken_n = 1'b0;
          w_taken_n  = 1'b0;
        end
      end
      W_MEM: begin
        wr_state_n = W_RESP;
        bvalid_n   = 1'b1;
        bresp_n    = wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wr_state_n = W_IDLE;
          bvalid_n   = 1'b0;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
        end
      end
      default: wr_state_n = W_IDLE;
    endcase
  end

  // Write FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= W_IDLE;
      aw_taken      <= 1'b0;
      w_taken       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      wr_state      <= wr_state_n;
      aw_taken      <= aw_taken_n;
      w_taken       <= w_taken_n;
      s_axi_awready <= awready_n;
      s_axi_wready  <= wready_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_bresp   <= bresp_n;
    end
  end

  // Read FSM next state; R_MEM stalls while the write side holds the RAM port.
  always_comb begin
    rd_state_n = rd_state;
    arready_n  = s_axi_arready;
    rvalid_n   = s_axi_rvalid;
    rresp_n    = s_axi_rresp;
    case (rd_state)
      R_IDLE: begin
        arready_n = !ar_hs;
        if (ar_hs) rd_state_n = R_MEM;
      end
      R_MEM: begin
        if (!w_mem) begin
          rd_state_n = R_RESP;
          rvalid_n   = 1'b1;
          rresp_n    = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rd_state_n = R_IDLE;
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  // Read FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      rd_state      <= rd_state_n;
      s_axi_arready <= arready_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_rresp   <= rresp_n;
    end
  end

endmodule

// File: tb/tb_axi4lite_bram_slave.sv
// Self-checking bench for axi4lite_bram_slave: a table of write/read vectors plus
// hand sequences for ordering, port contention, backpressure and reset.
// Responses are scored against queues filled when each request is driven.
module tb_axi4lite_bram_slave;
  import axi_lite_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  rd_exp_t    rq[$];
  logic [1:0] bq[$];
  vec_t       vecs[11];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  axi4lite_bram_slave #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (32'h0),
    .INIT_FILE   ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit need_aw, input bit need_w, input bit need_ar);
    int n = 0;
    while (!((!need_aw || s_axi_awready) && (!need_w || s_axi_wready) && (!need_ar || s_axi_arready))
           && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: readies never rose within 50 cycles");
    end
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] exp_resp);
    int lat;
    waitReady(1'b1, 1'b1, 1'b0);
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    bq.push_back(exp_resp);
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    lat = 1;
    while (!s_axi_bvalid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput("b_latency", 32'(lat), 32'd2);
    step();
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                        input int exp_lat);
    int lat;
    rd_exp_t e;
    waitReady(1'b0, 1'b0, 1'b1);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    e.data = exp_data;
    e.resp = exp_resp;
    rq.push_back(e);
    step();
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!s_axi_rvalid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput("r_latency", 32'(lat), 32'(exp_lat));
    step();
  endtask

  task automatic applyStimulus(input vec_t v);
    doWrite(v.addr, v.wdata, v.wstrb, v.bresp);
    doRead(v.addr, v.rdata, v.rresp, 2);
  endtask

  // Scoreboard: every completed B or R handshake is matched against the queue head.
  always @(negedge clk) begin : monitor
    logic [1:0] eb;
    rd_exp_t    er;
    if (!rst && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL b_unexpected: got bresp 0x%0h, want no response", s_axi_bresp);
      end else begin
        eb = bq.pop_front();
        checkOutput("bresp", 32'(s_axi_bresp), 32'(eb));
      end
    end
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL r_unexpected: got rdata 0x%08h, want no response", s_axi_rdata);
      end else begin
        er = rq.pop_front();
        checkOutput("rdata", s_axi_rdata, er.data);
        checkOutput("rresp", 32'(s_axi_rresp), 32'(er.resp));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat_b, lat_r, stable;
    bit saw_b;
    rd_exp_t e;

    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, RESP_OKAY,   32'hDEAD_BEEF, RESP_OKAY};
    vecs[1]  = '{32'h0000_0020, 32'h1122_3344, 4'b1111, RESP_OKAY,   32'h1122_3344, RESP_OKAY};
    vecs[2]  = '{32'h0000_0020, 32'h0000_AB00, 4'b0010, RESP_OKAY,   32'h1122_AB44, RESP_OKAY};
    vecs[3]  = '{32'h0000_0023, 32'hCC00_0000, 4'b1000, RESP_OKAY,   32'hCC22_AB44, RESP_OKAY};
    vecs[4]  = '{32'h0000_0030, 32'h0BAD_F00D, 4'b1111, RESP_OKAY,   32'h0BAD_F00D, RESP_OKAY};
    vecs[5]  = '{32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY,   32'h0BAD_F00D, RESP_OKAY};
    vecs[6]  = '{32'h0000_0000, 32'h600D_F00D, 4'b1111, RESP_OKAY,   32'h600D_F00D, RESP_OKAY};
    vecs[7]  = '{32'h0000_1000, 32'hBAAD_BAAD, 4'b1111, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};
    vecs[8]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY,   32'h600D_F00D, RESP_OKAY};
    vecs[9]  = '{32'h0000_0FFC, 32'hA5A5_A5A5, 4'b1111, RESP_OKAY,   32'hA5A5_A5A5, RESP_OKAY};
    vecs[10] = '{32'hFFFF_FFFC, 32'h1234_5678, 4'b1111, RESP_SLVERR, 32'h0000_0000, RESP_SLVERR};

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
    checkOutput("rst_wready",  32'(s_axi_wready),  32'd0);
    checkOutput("rst_arready", 32'(s_axi_arready), 32'd0);
    checkOutput("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    checkOutput("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    checkOutput("rst_bresp",   32'(s_axi_bresp),   32'd0);
    checkOutput("rst_rresp",   32'(s_axi_rresp),   32'd0);
    checkOutput("rst_rdata",   s_axi_rdata,        32'd0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_awready", 32'(s_axi_awready), 32'd1);
    checkOutput("post_rst_wready",  32'(s_axi_wready),  32'd1);
    checkOutput("post_rst_arready", 32'(s_axi_arready), 32'd1);

    // Table-driven write-then-read vectors
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // W arrives three cycles before AW; only byte 1 is replaced
    doWrite(32'h40, 32'h1122_3344, 4'b1111, RESP_OKAY);
    waitReady(1'b1, 1'b1, 1'b0);
    s_axi_wdata  = 32'h0000_AB00;
    s_axi_wstrb  = 4'b0010;
    s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    checkOutput("w_first_wready",  32'(s_axi_wready),  32'd0);
    checkOutput("w_first_awready", 32'(s_axi_awready), 32'd1);
    step();
    step();
    s_axi_awaddr  = 32'h40;
    s_axi_awvalid = 1'b1;
    bq.push_back(RESP_OKAY);
    step();
    s_axi_awvalid = 1'b0;
    lat_b = 1;
    while (!s_axi_bvalid && lat_b < 20) begin
      step();
      lat_b++;
    end
    checkOutput("w_first_b_latency", 32'(lat_b), 32'd2);
    step();
    doRead(32'h40, 32'h1122_AB44, RESP_OKAY, 2);

    // Read collides with the write cycle on the same word
    doWrite(32'h50, 32'h7777_7777, 4'b1111, RESP_OKAY);
    waitReady(1'b1, 1'b1, 1'b1);
    s_axi_awaddr  = 32'h50;
    s_axi_wdata   = 32'h0000_0005;
    s_axi_wstrb   = 4'b1111;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 32'h50;
    s_axi_arvalid = 1'b1;
    s_axi_bready  = 1'b1;
    s_axi_rready  = 1'b1;
    bq.push_back(RESP_OKAY);
    e.data = 32'h0000_0005;
    e.resp = RESP_OKAY;
    rq.push_back(e);
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    lat_b = 0;
    lat_r = 0;
    for (int c = 1; c <= 8; c++) begin
      if (s_axi_bvalid && lat_b == 0) lat_b = c;
      if (s_axi_rvalid && lat_r == 0) lat_r = c;
      step();
    end
    checkOutput("collide_b_latency", 32'(lat_b), 32'd2);
    checkOutput("collide_r_latency", 32'(lat_r), 32'd3);

    // rready held low for 10 cycles while a write completes underneath
    waitReady(1'b0, 1'b0, 1'b1);
    s_axi_araddr  = 32'h10;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    e.data = 32'hDEAD_BEEF;
    e.resp = RESP_OKAY;
    rq.push_back(e);
    step();
    s_axi_arvalid = 1'b0;
    lat_r = 1;
    while (!s_axi_rvalid && lat_r < 20) begin
      step();
      lat_r++;
    end
    checkOutput("bp_r_latency", 32'(lat_r), 32'd2);
    s_axi_awaddr  = 32'h60;
    s_axi_wdata   = 32'h1234_5678;
    s_axi_wstrb   = 4'b1111;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    bq.push_back(RESP_OKAY);
    stable = 0;
    saw_b  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (s_axi_rvalid && s_axi_rdata == 32'hDEAD_BEEF && s_axi_rresp == RESP_OKAY) stable++;
      if (s_axi_bvalid) saw_b = 1'b1;
      step();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
    end
    checkOutput("bp_r_stable_cycles", 32'(stable), 32'd10);
    checkOutput("bp_write_done", 32'(saw_b), 32'd1);
    s_axi_rready = 1'b1;
    step();
    doRead(32'h60, 32'h1234_5678, RESP_OKAY, 2);

    // Reset pulsed while a write response is waiting on bready
    waitReady(1'b1, 1'b1, 1'b0);
    s_axi_awaddr  = 32'h70;
    s_axi_wdata   = 32'h0000_0099;
    s_axi_wstrb   = 4'b1111;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b0;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    step();
    step();
    checkOutput("rst_mid_bvalid_before", 32'(s_axi_bvalid), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rst_mid_bvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rst_mid_awready", 32'(s_axi_awready), 32'd0);
    rst = 1'b0;
    s_axi_bready = 1'b1;
    step();
    checkOutput("rst_mid_awready_after", 32'(s_axi_awready), 32'd1);
    checkOutput("rst_mid_wready_after",  32'(s_axi_wready),  32'd1);
    checkOutput("rst_mid_arready_after", 32'(s_axi_arready), 32'd1);
    checkOutput("rst_mid_bvalid_after",  32'(s_axi_bvalid),  32'd0);
    doRead(32'h10, 32'hDEAD_BEEF, RESP_OKAY, 2);

    step();
    step();
    checkOutput("b_queue_drained", 32'(bq.size()), 32'd0);
    checkOutput("r_queue_drained", 32'(rq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
